// File: rtl/ubit_acc_if.sv
// Stream/handshake bundle for ubit_acc: start/bit inputs, partial sum in,
// partial sum out with valid/ready.
//
// Handshake: o_psum is transferred on any rising clk edge where o_valid=1 and i_ready=1.
// While o_valid=1 and i_ready=0, o_psum and o_valid hold.
interface ubit_acc_if #(
  parameter int ACC_WIDTH = 20
);
  logic                 i_start;
  logic                 i_bit;
  logic                 i_bit_valid;
  logic [ACC_WIDTH-1:0] i_psum;
  logic                 i_ready;
  logic [ACC_WIDTH-1:0] o_psum;
  logic                 o_valid;
  logic                 o_busy;

  modport master (
    output i_start, i_bit, i_bit_valid, i_psum, i_ready,
    input  o_psum, o_valid, o_busy
  );

  modport slave (
    input  i_start, i_bit, i_bit_valid, i_psum, i_ready,
    output o_psum, o_valid, o_busy
  );
endinterface

// File: rtl/ubit_acc.sv
// Unary bitstream accumulator: counts ones over a 2^CYCLE_BITS window and adds
// the result to a latched partial sum. Define UBIT_ACC_BIPOLAR_EN for bipolar coding.
module ubit_acc #(
  parameter int CYCLE_BITS = 8,
  parameter int ACC_WIDTH  = 20
) (
  input  logic           clk,
  input  logic           rst,
  ubit_acc_if.slave      bus,
  output logic [1:0]     o_dbg_state
);
  localparam int OW = CYCLE_BITS + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [OW-1:0]         ones_q, ones_d;
  logic [CYCLE_BITS-1:0] cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]  psum_lat_q, psum_lat_d;
  logic [ACC_WIDTH-1:0]  o_psum_q, o_psum_d;
  logic                  o_valid_q, o_valid_d;
  logic                  busy_q, busy_d;
  logic [OW-1:0]         ones_nxt;
  logic [ACC_WIDTH-1:0]  contrib;

  always_comb begin
    ones_nxt = ones_q + OW'(bus.i_bit);
`ifdef UBIT_ACC_BIPOLAR_EN
    // 2*ones - 2^CYCLE_BITS, computed modulo 2^ACC_WIDTH so it is already sign-extended
    contrib = ACC_WIDTH'({ones_nxt, 1'b0}) - (ACC_WIDTH'(1) << CYCLE_BITS);
`else
    contrib = ACC_WIDTH'(ones_nxt);
`endif
  end

  always_comb begin
    state_d    = state_q;
    ones_d     = ones_q;
    cnt_d      = cnt_q;
    psum_lat_d = psum_lat_q;
    o_psum_d   = o_psum_q;
    o_valid_d  = o_valid_q;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          psum_lat_d = bus.i_psum;
          ones_d     = '0;
          cnt_d      = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (bus.i_bit_valid) begin
          cnt_d  = cnt_q + CYCLE_BITS'(1);
          ones_d = ones_nxt;
          if (cnt_q == {CYCLE_BITS{1'b1}}) begin
            o_psum_d  = psum_lat_q + contrib;
            o_valid_d = 1'b1;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.i_ready) begin
          o_valid_d = 1'b0;
          // A start coinciding with the handshake chains straight into the next window
          if (bus.i_start) begin
            psum_lat_d = bus.i_psum;
            ones_d     = '0;
            cnt_d      = '0;
            state_d    = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        o_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ones_q     <= '0;
      cnt_q      <= '0;
      psum_lat_q <= '0;
      o_psum_q   <= '0;
      o_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ones_q     <= ones_d;
      cnt_q      <= cnt_d;
      psum_lat_q <= psum_lat_d;
      o_psum_q   <= o_psum_d;
      o_valid_q  <= o_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.o_psum  = o_psum_q;
  assign bus.o_valid = o_valid_q;
  assign bus.o_busy  = busy_q;
  assign o_dbg_state = state_q;
endmodule

// File: doc/ubit_acc.md
UBIT_ACC -- requirements
Module: ubit_acc

Interface
REQ-001 SHALL have parameter CYCLE_BITS, default 8: the window is 2^CYCLE_BITS bitstream cycles, matching the 8-bit Sobol period.
REQ-002 SHALL have parameter ACC_WIDTH, default 20: signed partial-sum width.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port i_start, input, 1 bit: begin a new accumulation window.
REQ-006 SHALL have port i_bit, input, 1 bit: product bit from the upstream multiplier border stage (its o_bit).
REQ-007 SHALL have port i_bit_valid, input, 1 bit: i_bit is meaningful this cycle.
REQ-008 SHALL have port i_psum, input, ACC_WIDTH bits: signed incoming partial sum, latched on start.
REQ-009 SHALL have port i_ready, input, 1 bit: downstream accepts o_psum.
REQ-010 SHALL have port o_psum, output, ACC_WIDTH bits: signed outgoing partial sum.
REQ-011 SHALL have port o_valid, output, 1 bit: o_psum is valid.
REQ-012 SHALL have port o_busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 SHALL implement the states IDLE, RUN and HOLD.
REQ-014 In IDLE, i_start=1 SHALL latch i_psum, clear the ones counter and the bit counter, and enter RUN.
REQ-015 In RUN, each cycle with i_bit_valid=1 SHALL increment the bit counter and add i_bit to the ones counter; i_bit_valid=0 SHALL hold both counters.
REQ-016 The ones counter SHALL be CYCLE_BITS+1 bits wide so that an all-ones window (2^CYCLE_BITS) is representable; the bit counter SHALL be CYCLE_BITS bits wide.
REQ-017 On the valid bit at which the bit counter equals 2^CYCLE_BITS-1, the block SHALL register o_psum = latched psum + contribution, enter HOLD, and assert o_valid on the next cycle (latency of 1 cycle after the last accepted bit).
REQ-018 The contribution SHALL be sign-extended to ACC_WIDTH, and the addition SHALL wrap modulo 2^ACC_WIDTH with no saturation.
REQ-019 In HOLD, o_valid SHALL stay 1 and o_psum SHALL stay stable until i_ready=1; on that handshake the state SHALL become IDLE.
REQ-020 If i_start=1 in the same cycle as the HOLD handshake, the block SHALL go directly to RUN, latching i_psum, to support back-to-back windows.
REQ-021 i_start SHALL be ignored in RUN, and in HOLD without a handshake.
REQ-022 i_bit and i_bit_valid SHALL be ignored in IDLE and HOLD.
REQ-023 o_valid SHALL be 0 in IDLE and RUN; o_psum SHALL retain its last value outside HOLD.

Reset
REQ-024 rst=1 SHALL immediately force the state to IDLE, both counters and the latched psum to 0, o_psum=0, o_valid=0 and o_busy=0, even in the middle of RUN or HOLD.
REQ-025 After rst deasserts, the block SHALL wait in IDLE for i_start; partial window data SHALL be discarded.

Configuration
REQ-026 Macro UBIT_ACC_BIPOLAR_EN SHALL select the coding of the contribution.
REQ-027 With the macro defined, contribution = 2*ones - 2^CYCLE_BITS, giving a signed bipolar value.
REQ-028 Without the macro, contribution = ones, giving an unsigned unipolar value that is zero-extended.

Verification (CYCLE_BITS=8, ACC_WIDTH=20)
REQ-029 i_psum=0, 256 valid bits all 1 -> o_psum=256 in both modes; o_valid rises 1 cycle after the 256th bit.
REQ-030 i_psum=100, 256 alternating bits 1,0 -> o_psum=228 in unipolar mode, 100 in bipolar mode.
REQ-031 Bipolar mode, i_psum=0, 256 zero bits -> o_psum=0xFFF00 (-256).
REQ-032 256 one-bits with i_bit_valid toggling every cycle (512 cycles total), plus i_bit=0 on invalid cycles -> o_psum=256; invalid bits are not counted.
REQ-033 Backpressure: i_ready=0 for 10 cycles in HOLD with i_start pulsed -> o_psum stable, o_valid=1, start ignored; then i_ready=1 with i_start=1 -> next cycle RUN, o_valid=0.
REQ-034 rst=1 after 100 bits in RUN -> o_busy=0, o_valid=0, o_psum=0 immediately; later bits with no i_start -> no o_valid.
